pipe_hazard_ctrl: RTL and testbench

- Interlock and sequencing controller for the 5-stage pipeline (IF, ID, EX, MA, RW).
- Consumes the 22-bit decoded control word from the control unit at ID, plus register fields and the EX branch outcome.
- Produces stall, bubble and flush strobes for the pipeline registers.
- Detects load-use hazards and holds the pipeline for multi-cycle mul/div/mod.
- Kills wrong-path instructions on a taken branch.

---
 rtl/pipe_pkg.sv | 39 +++
 rtl/mc_occupancy_cnt.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: control-word bit
// positions, control-word width and the interlock FSM state type.
package pipe_pkg;

   localparam int unsigned CTL_W          = 22;

   localparam int unsigned CTL_IS_ST      = 0;
   localparam int unsigned CTL_IS_LD      = 1;
   localparam int unsigned CTL_IS_BEQ     = 2;
   localparam int unsigned CTL_IS_BGT     = 3;
   localparam int unsigned CTL_IS_RET     = 4;
   localparam int unsigned CTL_IS_IMM     = 5;
   localparam int unsigned CTL_IS_WB      = 6;
   localparam int unsigned CTL_IS_UBRANCH = 7;
   localparam int unsigned CTL_IS_CALL    = 8;
   localparam int unsigned CTL_IS_ADD     = 9;
   localparam int unsigned CTL_IS_SUB     = 10;
   localparam int unsigned CTL_IS_CMP     = 11;
   localparam int unsigned CTL_IS_MUL     = 12;
   localparam int unsigned CTL_IS_DIV     = 13;
   localparam int unsigned CTL_IS_MOD     = 14;
   localparam int unsigned CTL_IS_LSL     = 15;
   localparam int unsigned CTL_IS_LSR     = 16;
   localparam int unsigned CTL_IS_ASR     = 17;
   localparam int unsigned CTL_IS_OR      = 18;
   localparam int unsigned CTL_IS_AND     = 19;
   localparam int unsigned CTL_IS_NOT     = 20;
   localparam int unsigned CTL_IS_MOV     = 21;

   typedef enum logic {
      RUN     = 1'b0,
      MC_BUSY = 1'b1
   } hz_state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mc_occupancy_cnt.sv
// Loadable down-counter tracking the remaining EX cycles of a multi-cycle
// operation; o_done flags a zero count.
module mc_occupancy_cnt #(
   parameter int unsigned MAX_LAT = 8,
   localparam int unsigned CNT_W  = $clog2(MAX_LAT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_done
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_done = (r_cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Interlock/sequencing controller for the 5-stage pipeline: load-use stall,
// multi-cycle mul/div/mod hold, taken-branch flush. HAZ_PERF_CNT_EN adds counters.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned MUL_LAT = 3,
   parameter int unsigned DIV_LAT = 8,
   parameter int unsigned NREG_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [CTL_W-1:0]  id_ctrl,
   input  logic [NREG_W-1:0] id_rs1,
   input  logic [NREG_W-1:0] id_rs2,
   input  logic [NREG_W-1:0] id_rd,
   input  logic [1:0]        id_src_vld,
   input  logic              ex_branch_taken,
   output logic              stall_if,
   output logic              stall_id,
   output logic              stall_ex,
   output logic              bubble_ex,
   output logic              bubble_ma,
   output logic              flush,
   output logic              mc_start,
   output logic              busy
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0]       perf_ld_stall,
   output logic [31:0]       perf_mc_stall,
   output logic [31:0]       perf_flush
`endif
);

   localparam int unsigned     MAX_LAT = max_u(MUL_LAT, DIV_LAT);
   localparam int unsigned     CNT_W   = $clog2(MAX_LAT);
   localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 2);
   localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 2);

   hz_state_e         r_state;
   logic              r_mc_start;
   logic              r_ex_vld;
   logic              r_ex_isld;
   logic              r_ex_wb;
   logic [NREG_W-1:0] r_ex_rd;

   logic              w_run;
   logic              w_busy;
   logic              w_src_hit;
   logic              w_hz;
   logic              w_flush;
   logic              w_ld_stall;
   logic              w_stall_id;
   logic              w_bubble_ex;
   logic              w_issue;
   logic              w_is_mc;
   logic              w_mc_load;
   logic [CNT_W-1:0]  w_mc_ld_val;
   logic              w_cnt_done;
   logic              w_unused_ctrl;

   assign w_run  = (r_state == RUN);
   assign w_busy = (r_state == MC_BUSY);

   assign w_src_hit = (id_src_vld[0] && (id_rs1 == r_ex_rd)) ||
                      (id_src_vld[1] && (id_rs2 == r_ex_rd));
   assign w_hz      = w_run & id_valid & r_ex_vld & r_ex_isld & r_ex_wb & w_src_hit;

   // A branch resolved during MC_BUSY is illegal and therefore ignored here.
   assign w_flush     = w_run & ex_branch_taken;
   assign w_ld_stall  = w_hz & ~w_flush;
   assign w_stall_id  = w_ld_stall | w_busy;
   assign w_bubble_ex = w_flush | w_hz;
   assign w_issue     = id_valid & ~w_stall_id & ~w_flush;

   assign w_is_mc     = id_ctrl[CTL_IS_MUL] | id_ctrl[CTL_IS_DIV] | id_ctrl[CTL_IS_MOD];
   assign w_mc_load   = w_run & w_issue & w_is_mc;
   assign w_mc_ld_val = id_ctrl[CTL_IS_MUL] ? MUL_LD : DIV_LD;

   assign w_unused_ctrl = ^{id_ctrl[CTL_IS_ST], id_ctrl[CTL_IS_IMM:CTL_IS_BEQ],
                            id_ctrl[CTL_IS_CMP:CTL_IS_UBRANCH], id_ctrl[CTL_IS_MOV:CTL_IS_LSL]};

   mc_occupancy_cnt #(
      .MAX_LAT (MAX_LAT)
   ) u_mc_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_mc_load),
      .i_load_val (w_mc_ld_val),
      .i_dec      (w_busy),
      .o_done     (w_cnt_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= RUN;
         r_mc_start <= 1'b0;
      end else begin
         r_mc_start <= w_mc_load;
         case (r_state)
            RUN:     if (w_mc_load)  r_state <= MC_BUSY;
            MC_BUSY: if (w_cnt_done) r_state <= RUN;
            default: r_state <= RUN;
         endcase
      end
   end

   // The shadow follows ID/EX: cleared by a bubble, held while ID is stalled,
   // otherwise it takes whatever ID presents (invalid slots clear it).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_vld  <= 1'b0;
         r_ex_isld <= 1'b0;
         r_ex_wb   <= 1'b0;
         r_ex_rd   <= '0;
      end else if (w_bubble_ex) begin
         r_ex_vld  <= 1'b0;
         r_ex_isld <= 1'b0;
         r_ex_wb   <= 1'b0;
         r_ex_rd   <= '0;
      end else if (!w_stall_id) begin
         r_ex_vld  <= id_valid;
         r_ex_isld <= id_ctrl[CTL_IS_LD];
         r_ex_wb   <= id_ctrl[CTL_IS_WB];
         r_ex_rd   <= id_rd;
      end
   end

   assign stall_if  = w_stall_id;
   assign stall_id  = w_stall_id;
   assign stall_ex  = w_busy;
   assign bubble_ex = w_bubble_ex;
   assign bubble_ma = w_busy;
   assign flush     = w_flush;
   assign mc_start  = r_mc_start;
   assign busy      = w_busy;

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] r_perf_ld;
   logic [31:0] r_perf_mc;
   logic [31:0] r_perf_fl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_ld <= '0;
         r_perf_mc <= '0;
         r_perf_fl <= '0;
      end else begin
         if (w_ld_stall && (r_perf_ld != '1)) r_perf_ld <= r_perf_ld + 32'd1;
         if (w_busy     && (r_perf_mc != '1)) r_perf_mc <= r_perf_mc + 32'd1;
         if (w_flush    && (r_perf_fl != '1)) r_perf_fl <= r_perf_fl + 32'd1;
      end
   end

   assign perf_ld_stall = r_perf_ld;
   assign perf_mc_stall = r_perf_mc;
   assign perf_flush    = r_perf_fl;
`endif

   a_no_branch_in_mc_busy: assert property (
      @(posedge clk) disable iff (!rst_n) !(ex_branch_taken && (r_state == MC_BUSY))
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl (MUL_LAT=3, DIV_LAT=8).
module tb_pipe_hazard_ctrl;
   import pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        id_valid = 1'b0;
   logic [21:0] id_ctrl = '0;
   logic [3:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic [1:0]  id_src_vld = '0;
   logic        ex_branch_taken = 1'b0;
   logic        stall_if, stall_id, stall_ex, bubble_ex, bubble_ma, flush, mc_start, busy;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0] perf_ld_stall, perf_mc_stall, perf_flush;
`endif

   int n_checks = 0;
   int n_errors = 0;

   pipe_hazard_ctrl #(.MUL_LAT(3), .DIV_LAT(8), .NREG_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_src_vld(id_src_vld),
      .ex_branch_taken(ex_branch_taken),
      .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
      .bubble_ex(bubble_ex), .bubble_ma(bubble_ma), .flush(flush),
      .mc_start(mc_start), .busy(busy)
`ifdef HAZ_PERF_CNT_EN
      , .perf_ld_stall(perf_ld_stall), .perf_mc_stall(perf_mc_stall), .perf_flush(perf_flush)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       p_ld;
      logic       p_wb;
      logic [3:0] p_rd;
      logic [3:0] c_rs1;
      logic [3:0] c_rs2;
      logic [1:0] c_src;
      logic       br;
      logic       e_stall;
      logic       e_bubble;
      logic       e_flush;
   } vec_t;

   vec_t vt[11];

   function automatic logic [21:0] cbit(input int unsigned b);
      logic [21:0] one;
      one = 22'd1;
      return one << b;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [21:0] c, input logic [3:0] r1,
                        input logic [3:0] r2, input logic [3:0] rd, input logic [1:0] s,
                        input logic br);
      id_valid = v; id_ctrl = c; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
      id_src_vld = s; ex_branch_taken = br;
   endtask

   task automatic idle();
      drive(1'b0, '0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0);
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic chk_all0(input string nm);
      chk({nm, " stall_if"}, stall_if, 0);
      chk({nm, " stall_id"}, stall_id, 0);
      chk({nm, " stall_ex"}, stall_ex, 0);
      chk({nm, " bubble_ex"}, bubble_ex, 0);
      chk({nm, " bubble_ma"}, bubble_ma, 0);
      chk({nm, " flush"}, flush, 0);
      chk({nm, " mc_start"}, mc_start, 0);
      chk({nm, " busy"}, busy, 0);
   endtask

   task automatic wait_not_busy(input string nm);
      for (int i = 0; i < 30; i++) begin
         if (!busy) break;
         next_cycle();
         @(negedge clk);
      end
      chk({nm, " busy timeout"}, busy, 0);
   endtask

   // Multi-cycle op issued at T: busy/stall_ex for lat-1 cycles, mc_start on the first.
   task automatic mc_seq(input int unsigned b, input int unsigned lat, input bit b2b, input string nm);
      int nbusy;
      idle(); next_cycle();
      drive(1'b1, cbit(b) | cbit(CTL_IS_WB), 4'd1, 4'd2, 4'd7, 2'b11, 1'b0);
      @(negedge clk);
      chk({nm, " issue mc_start"}, mc_start, 0);
      chk({nm, " issue stall_if"}, stall_if, 0);
      next_cycle();
      if (b2b) drive(1'b1, cbit(b) | cbit(CTL_IS_WB), 4'd1, 4'd2, 4'd8, 2'b11, 1'b0);
      else     drive(1'b1, cbit(CTL_IS_ADD) | cbit(CTL_IS_WB), 4'd1, 4'd2, 4'd8, 2'b11, 1'b0);
      for (int k = 1; k < int'(lat); k++) begin
         @(negedge clk);
         chk($sformatf("%s busy c%0d", nm, k), busy, 1);
         chk($sformatf("%s stall_ex c%0d", nm, k), stall_ex, 1);
         chk($sformatf("%s stall_if c%0d", nm, k), stall_if, 1);
         chk($sformatf("%s stall_id c%0d", nm, k), stall_id, 1);
         chk($sformatf("%s bubble_ma c%0d", nm, k), bubble_ma, 1);
         chk($sformatf("%s bubble_ex c%0d", nm, k), bubble_ex, 0);
         chk($sformatf("%s mc_start c%0d", nm, k), mc_start, (k == 1) ? 1 : 0);
         next_cycle();
      end
      @(negedge clk);
      chk({nm, " end busy"}, busy, 0);
      chk({nm, " end stall_ex"}, stall_ex, 0);
      chk({nm, " end stall_if"}, stall_if, 0);
      chk({nm, " end mc_start"}, mc_start, 0);
      next_cycle();
      idle();
      if (b2b) begin
         @(negedge clk);
         chk({nm, " b2b mc_start"}, mc_start, 1);
         nbusy = 0;
         for (int i = 0; i < 30; i++) begin
            if (!busy) break;
            nbusy++;
            next_cycle();
            @(negedge clk);
         end
         chk({nm, " b2b busy cycles"}, nbusy, lat - 1);
      end
   endtask

   initial begin
      vt[0]  = '{1'b1, 1'b1, 4'd3,  4'd3, 4'd2,  2'b01, 1'b0, 1'b1, 1'b1, 1'b0};
      vt[1]  = '{1'b1, 1'b1, 4'd3,  4'd4, 4'd2,  2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[2]  = '{1'b1, 1'b1, 4'd3,  4'd1, 4'd3,  2'b10, 1'b0, 1'b1, 1'b1, 1'b0};
      vt[3]  = '{1'b1, 1'b1, 4'd3,  4'd1, 4'd3,  2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[4]  = '{1'b1, 1'b1, 4'd0,  4'd0, 4'd0,  2'b01, 1'b0, 1'b1, 1'b1, 1'b0};
      vt[5]  = '{1'b1, 1'b0, 4'd3,  4'd3, 4'd2,  2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[6]  = '{1'b0, 1'b1, 4'd3,  4'd3, 4'd2,  2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[7]  = '{1'b1, 1'b1, 4'd5,  4'd5, 4'd2,  2'b01, 1'b1, 1'b0, 1'b1, 1'b1};
      vt[8]  = '{1'b1, 1'b1, 4'd9,  4'd1, 4'd2,  2'b11, 1'b1, 1'b0, 1'b1, 1'b1};
      vt[9]  = '{1'b1, 1'b1, 4'd15, 4'd2, 4'd15, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0};
      vt[10] = '{1'b1, 1'b1, 4'd3,  4'd3, 4'd3,  2'b00, 1'b0, 1'b0, 1'b0, 1'b0};

      #1 rst_n = 1'b0;
      #2 chk_all0("reset");
      @(negedge clk) rst_n = 1'b1;
      next_cycle();

      foreach (vt[i]) begin
         idle(); next_cycle();
         drive(1'b1, (vt[i].p_ld ? cbit(CTL_IS_LD) : '0) | (vt[i].p_wb ? cbit(CTL_IS_WB) : '0),
               4'd0, 4'd0, vt[i].p_rd, 2'b00, 1'b0);
         next_cycle();
         drive(1'b1, cbit(CTL_IS_ADD) | cbit(CTL_IS_WB), vt[i].c_rs1, vt[i].c_rs2, 4'd14,
               vt[i].c_src, vt[i].br);
         @(negedge clk);
         chk($sformatf("vec%0d stall_if", i), stall_if, vt[i].e_stall);
         chk($sformatf("vec%0d stall_id", i), stall_id, vt[i].e_stall);
         chk($sformatf("vec%0d bubble_ex", i), bubble_ex, vt[i].e_bubble);
         chk($sformatf("vec%0d flush", i), flush, vt[i].e_flush);
         chk($sformatf("vec%0d stall_ex", i), stall_ex, 0);
         next_cycle();
         ex_branch_taken = 1'b0;
         @(negedge clk);
         chk($sformatf("vec%0d next stall_if", i), stall_if, 0);
         chk($sformatf("vec%0d next bubble_ex", i), bubble_ex, 0);
         chk($sformatf("vec%0d next flush", i), flush, 0);
         next_cycle();
      end

      mc_seq(CTL_IS_MUL, 3, 1'b0, "mul");
      mc_seq(CTL_IS_DIV, 8, 1'b0, "div");
      mc_seq(CTL_IS_MOD, 8, 1'b0, "mod");
      mc_seq(CTL_IS_MUL, 3, 1'b1, "mul_b2b");

      // load-use in front of a mul: one bubble, then the mul issues
      idle(); next_cycle();
      drive(1'b1, cbit(CTL_IS_LD) | cbit(CTL_IS_WB), 4'd0, 4'd0, 4'd3, 2'b00, 1'b0);
      next_cycle();
      drive(1'b1, cbit(CTL_IS_MUL) | cbit(CTL_IS_WB), 4'd3, 4'd2, 4'd6, 2'b01, 1'b0);
      @(negedge clk);
      chk("ldmul stall_if", stall_if, 1);
      chk("ldmul bubble_ex", bubble_ex, 1);
      chk("ldmul mc_start early", mc_start, 0);
      next_cycle();
      @(negedge clk);
      chk("ldmul issue stall_if", stall_if, 0);
      chk("ldmul issue mc_start", mc_start, 0);
      next_cycle();
      idle();
      @(negedge clk);
      chk("ldmul mc_start", mc_start, 1);
      chk("ldmul busy", busy, 1);
      wait_not_busy("ldmul");

      // taken branch kills a mul sitting in ID
      next_cycle();
      drive(1'b1, cbit(CTL_IS_MUL) | cbit(CTL_IS_WB), 4'd1, 4'd2, 4'd6, 2'b11, 1'b1);
      @(negedge clk);
      chk("brkill flush", flush, 1);
      chk("brkill bubble_ex", bubble_ex, 1);
      chk("brkill stall_if", stall_if, 0);
      next_cycle();
      idle();
      @(negedge clk);
      chk("brkill mc_start", mc_start, 0);
      chk("brkill busy", busy, 0);
      next_cycle();
      @(negedge clk);
      chk("brkill busy2", busy, 0);

      // reset on the 3rd MC_BUSY cycle of a div
      next_cycle();
      drive(1'b1, cbit(CTL_IS_DIV) | cbit(CTL_IS_WB), 4'd1, 4'd2, 4'd6, 2'b11, 1'b0);
      next_cycle();
      drive(1'b1, cbit(CTL_IS_ADD) | cbit(CTL_IS_WB), 4'd1, 4'd2, 4'd8, 2'b11, 1'b0);
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("rstmid pre busy", busy, 1);
      #1 rst_n = 1'b0;
      #1 chk_all0("rstmid async");
      @(negedge clk) rst_n = 1'b1;
      next_cycle();
      @(negedge clk);
      chk("rstmid after busy", busy, 0);
      chk("rstmid after mc_start", mc_start, 0);
      chk("rstmid after stall_if", stall_if, 0);
      next_cycle();
      idle();
      @(negedge clk);
      chk("rstmid after2 mc_start", mc_start, 0);
      chk("rstmid after2 busy", busy, 0);

`ifdef HAZ_PERF_CNT_EN
      rst_n = 1'b0;
      #1 chk("perf reset ld", perf_ld_stall, 0);
      @(negedge clk) rst_n = 1'b1;
      next_cycle();
      drive(1'b1, cbit(CTL_IS_LD) | cbit(CTL_IS_WB), 4'd0, 4'd0, 4'd3, 2'b00, 1'b0);
      next_cycle();
      drive(1'b1, cbit(CTL_IS_ADD) | cbit(CTL_IS_WB), 4'd3, 4'd2, 4'd1, 2'b01, 1'b0);
      next_cycle();
      next_cycle();
      mc_seq(CTL_IS_MUL, 3, 1'b0, "perf mul");
      drive(1'b0, '0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b1);
      next_cycle();
      idle(); next_cycle();
      drive(1'b0, '0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b1);
      next_cycle();
      idle(); next_cycle();
      @(negedge clk);
      chk("perf_ld_stall", perf_ld_stall, 1);
      chk("perf_mc_stall", perf_mc_stall, 2);
      chk("perf_flush", perf_flush, 2);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
